// File: rtl/instr_prefetch_buffer_if.sv
// Signal bundle shared by the prefetch buffer, instruction memory and the core front end.
// The buffer uses the master view; the memory/core side uses the slave view.
interface instr_prefetch_buffer_if;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [29:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_rsp_valid, mem_rsp_data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_rsp_valid, mem_rsp_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetch queue with a single outstanding memory fetch.
// On redirect it flushes the queue and drops any stale in-flight response.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input logic                     clk,
  input logic                     reset,
  instr_prefetch_buffer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [29:0]      fetch_pc_q, fetch_pc_d;
  logic [29:0]      req_pc_q, req_pc_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [29:0]      pc_mem_q [DEPTH];
  logic [29:0]      pc_mem_d [DEPTH];

  logic             push;
  logic             pop;
  logic             issue;
  logic [CNT_W-1:0] occupancy;

  // Pop is left out of the issue test so the core's ready never reaches mem_req.
  always_comb begin
    push      = (state_q == WAIT) && bus.mem_rsp_valid && !bus.redirect;
    pop       = (count_q != '0) && bus.instr_ready && !bus.redirect;
    occupancy = count_q + CNT_W'(push);
    issue     = !reset && !bus.redirect && (occupancy < CNT_W'(DEPTH)) &&
                ((state_q == IDLE) || ((state_q == WAIT) && bus.mem_rsp_valid));
  end

  assign bus.mem_req     = issue;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = instr_mem_q[rd_ptr_q];
  assign bus.instr_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (bus.redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = bus.redirect_pc;
      // A request still in flight after this cycle must have its data thrown away.
      if ((state_q != IDLE) && !bus.mem_rsp_valid) begin
        state_d = DISCARD;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = bus.mem_rsp_data;
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
        IDLE:    if (issue) state_d = WAIT;
        WAIT:    if (bus.mem_rsp_valid) state_d = issue ? WAIT : IDLE;
        DISCARD: if (bus.mem_rsp_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (issue) begin
        fetch_pc_d = fetch_pc_q + 30'd1;
        req_pc_d   = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Checks instr_prefetch_buffer against a queue-level model of the fetch/flush rules,
// driven by a variable-latency memory model, a directed table and random traffic.
module tb_instr_prefetch_buffer;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  instr_prefetch_buffer_if bus ();
  instr_prefetch_buffer_if wbus ();

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(30'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(30'h3FFFFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .bus(wbus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of PCs the core should see, plus one outstanding-fetch slot.
  logic [29:0] m_q[$];
  bit          m_busy;
  bit          m_drop;
  logic [29:0] m_out_addr;
  logic [29:0] m_fpc;
  int          full_events;
  bit          was_full;

  // Memory model: single pending request answered after lat cycles.
  bit          mem_busy;
  int          mem_cnt;
  logic [29:0] mem_pend_addr;
  int          lat = 1;
  bit          inject_stray;
  bit          w_pend;
  logic [29:0] w_pend_addr;

  logic        obs_req, obs_valid, w_obs_req, w_obs_valid;
  logic [29:0] obs_addr, obs_pc, w_obs_addr, w_obs_pc;
  logic [31:0] obs_instr;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [29:0] exp_addr;
    logic        exp_valid;
    logic [29:0] exp_pc;
    logic        w_addr_chk;
    logic [29:0] w_addr;
    logic        w_pc_chk;
    logic [29:0] w_pc;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] memData(input logic [29:0] a);
    return {a, 2'b11} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_busy      = 1'b0;
    m_drop      = 1'b0;
    m_fpc       = 30'h0;
    was_full    = 1'b0;
    mem_busy    = 1'b0;
    w_pend      = 1'b0;
  endtask

  // One clock cycle: drive inputs at cycle start, check at the falling edge, then advance.
  task automatic applyStimulus(input logic ready, input logic redir, input logic [29:0] rpc);
    bit fire;
    bit push;
    bit pop;
    bit exp_req;

    bus.instr_ready = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    fire = 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        fire     = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    bus.mem_rsp_valid = fire || inject_stray;
    bus.mem_rsp_data  = fire ? memData(mem_pend_addr) : 32'hDEAD_BEEF;
    inject_stray      = 1'b0;

    wbus.instr_ready   = 1'b1;
    wbus.redirect      = 1'b0;
    wbus.redirect_pc   = 30'h0;
    wbus.mem_rsp_valid = w_pend;
    wbus.mem_rsp_data  = memData(w_pend_addr);

    @(negedge clk);
    obs_req     = bus.mem_req;
    obs_addr    = bus.mem_addr;
    obs_valid   = bus.instr_valid;
    obs_pc      = bus.instr_pc;
    obs_instr   = bus.instr;
    w_obs_req   = wbus.mem_req;
    w_obs_addr  = wbus.mem_addr;
    w_obs_valid = wbus.instr_valid;
    w_obs_pc    = wbus.instr_pc;

    push    = m_busy && !m_drop && bus.mem_rsp_valid && !redir;
    exp_req = !redir && (!m_busy || (!m_drop && bus.mem_rsp_valid)) &&
              ((m_q.size() + int'(push)) < DEPTH);
    pop     = (m_q.size() != 0) && ready && !redir;

    checkOutput("mem_req", obs_req, exp_req);
    if (exp_req) checkOutput("mem_addr", obs_addr, m_fpc);
    checkOutput("instr_valid", obs_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      checkOutput("instr_pc", obs_pc, m_q[0]);
      checkOutput("instr", obs_instr, memData(m_q[0]));
    end

    if (obs_req) begin
      checkOutput("single_outstanding", mem_busy, 1'b0);
      mem_busy      = 1'b1;
      mem_cnt       = lat;
      mem_pend_addr = obs_addr;
    end
    w_pend      = w_obs_req;
    w_pend_addr = w_obs_addr;

    if (redir) begin
      m_q.delete();
      m_fpc = rpc;
      if (m_busy && bus.mem_rsp_valid) m_busy = 1'b0;
      m_drop = m_busy;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(m_out_addr);
      if (m_busy && bus.mem_rsp_valid) m_busy = 1'b0;
      if (exp_req) begin
        m_busy     = 1'b1;
        m_drop     = 1'b0;
        m_out_addr = m_fpc;
        m_fpc      = m_fpc + 30'd1;
      end
    end
    if ((m_q.size() == DEPTH) && !was_full) full_events++;
    was_full = (m_q.size() == DEPTH);

    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit mid);
    #2;
    reset              = 1'b1;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 30'h0;
    bus.instr_ready    = 1'b1;
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_data   = 32'hBAD0_BAD0;
    wbus.redirect      = 1'b0;
    wbus.redirect_pc   = 30'h0;
    wbus.instr_ready   = 1'b1;
    wbus.mem_rsp_valid = 1'b1;
    wbus.mem_rsp_data  = 32'hBAD0_BAD0;
    if (mid) begin
      #1;
      checkOutput("async_clear_valid", bus.instr_valid, 1'b0);
      checkOutput("async_clear_req", bus.mem_req, 1'b0);
    end
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_instr_valid", bus.instr_valid, 1'b0);
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_instr_pc", bus.instr_pc, 30'h0);
    checkOutput("rst_wrap_instr_pc", wbus.instr_pc, 30'h0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    inject_stray = 1'b1;
  endtask

  task automatic waitMem(input int cnt);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (mem_busy && mem_cnt == cnt) hit = 1'b1;
      else applyStimulus(1'b1, 1'b0, 30'h0);
    end
    if (!hit) hit = mem_busy && (mem_cnt == cnt);
    checkOutput("wait_mem_timeout", hit, 1'b1);
  endtask

  task automatic runUntilReq(input string name, input logic [29:0] exp);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 30'h0);
      if (obs_req) hit = 1'b1;
    end
    checkOutput({name, "_seen"}, hit, 1'b1);
    if (hit) checkOutput(name, obs_addr, exp);
  endtask

  task automatic runUntilValid(input string name, input logic [29:0] exp);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 30'h0);
      if (obs_valid) hit = 1'b1;
    end
    checkOutput({name, "_seen"}, hit, 1'b1);
    if (hit) checkOutput(name, obs_pc, exp);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pops;
    logic [29:0] rpc;

    // ready, req, addr, valid, pc, wrap-addr chk, wrap addr, wrap-pc chk, wrap pc
    vecs[0]  = '{1'b0, 1'b1, 30'd0, 1'b0, 30'd0, 1'b1, 30'h3FFFFFFE, 1'b0, 30'd0};
    vecs[1]  = '{1'b0, 1'b1, 30'd1, 1'b0, 30'd0, 1'b1, 30'h3FFFFFFF, 1'b0, 30'd0};
    vecs[2]  = '{1'b0, 1'b1, 30'd2, 1'b1, 30'd0, 1'b1, 30'h0,        1'b1, 30'h3FFFFFFE};
    vecs[3]  = '{1'b0, 1'b1, 30'd3, 1'b1, 30'd0, 1'b1, 30'h1,        1'b1, 30'h3FFFFFFF};
    vecs[4]  = '{1'b0, 1'b0, 30'd0, 1'b1, 30'd0, 1'b0, 30'h0,        1'b1, 30'h0};
    vecs[5]  = '{1'b0, 1'b0, 30'd0, 1'b1, 30'd0, 1'b0, 30'h0,        1'b1, 30'h1};
    vecs[6]  = '{1'b1, 1'b0, 30'd0, 1'b1, 30'd0, 1'b0, 30'h0,        1'b0, 30'h0};
    vecs[7]  = '{1'b1, 1'b1, 30'd4, 1'b1, 30'd1, 1'b0, 30'h0,        1'b0, 30'h0};
    vecs[8]  = '{1'b1, 1'b1, 30'd5, 1'b1, 30'd2, 1'b0, 30'h0,        1'b0, 30'h0};
    vecs[9]  = '{1'b1, 1'b1, 30'd6, 1'b1, 30'd3, 1'b0, 30'h0,        1'b0, 30'h0};
    vecs[10] = '{1'b0, 1'b1, 30'd7, 1'b1, 30'd4, 1'b0, 30'h0,        1'b0, 30'h0};

    full_events = 0;
    lat = 1;
    doReset(1'b0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].ready, 1'b0, 30'h0);
      checkOutput("tbl_req", obs_req, vecs[i].exp_req);
      if (vecs[i].exp_req) checkOutput("tbl_addr", obs_addr, vecs[i].exp_addr);
      checkOutput("tbl_valid", obs_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) checkOutput("tbl_pc", obs_pc, vecs[i].exp_pc);
      if (vecs[i].w_addr_chk) begin
        checkOutput("wrap_req", w_obs_req, 1'b1);
        checkOutput("wrap_addr", w_obs_addr, vecs[i].w_addr);
      end
      if (vecs[i].w_pc_chk) begin
        checkOutput("wrap_valid", w_obs_valid, 1'b1);
        checkOutput("wrap_pc", w_obs_pc, vecs[i].w_pc);
      end
    end

    $display("[TB] sustained throughput with latency 1");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 30'h0);
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 30'h0);
      if (obs_valid) pops++;
    end
    checkOutput("throughput", pops, 10);

    $display("[TB] latency 3 streaming");
    lat = 3;
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 30'h0);

    $display("[TB] redirect with a request outstanding");
    waitMem(3);
    applyStimulus(1'b1, 1'b1, 30'h100);
    applyStimulus(1'b1, 1'b0, 30'h0);
    checkOutput("redir_valid_low", obs_valid, 1'b0);
    checkOutput("redir_no_req", obs_req, 1'b0);
    runUntilReq("redir_first_addr", 30'h100);
    runUntilValid("redir_first_pc", 30'h100);

    $display("[TB] redirect coinciding with a response");
    lat = 2;
    waitMem(1);
    applyStimulus(1'b1, 1'b1, 30'h30);
    applyStimulus(1'b1, 1'b0, 30'h0);
    checkOutput("same_cycle_req", obs_req, 1'b1);
    checkOutput("same_cycle_addr", obs_addr, 30'h30);
    runUntilValid("same_cycle_pc", 30'h30);

    $display("[TB] back-to-back redirects while discarding");
    lat = 3;
    waitMem(3);
    applyStimulus(1'b1, 1'b1, 30'h20);
    applyStimulus(1'b1, 1'b1, 30'h40);
    runUntilReq("b2b_addr", 30'h40);
    runUntilValid("b2b_pc", 30'h40);

    $display("[TB] reset during operation");
    lat = 2;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 30'h0);
    doReset(1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 30'h0);

    $display("[TB] fill and drain rounds");
    lat = 1;
    full_events = 0;
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 30'h0);
      for (int i = 0; i < 8; i++) applyStimulus(1'($urandom_range(0, 3) != 0), 1'b0, 30'h0);
    end
    checkOutput("full_rounds", full_events >= 10, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) lat = int'($urandom_range(1, 4));
      rpc = 30'($urandom());
      if ($urandom_range(0, 19) == 0) applyStimulus(1'($urandom_range(0, 1)), 1'b1, rpc);
      else applyStimulus(1'($urandom_range(0, 1)), 1'b0, 30'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
